// File: rtl/kamus_decode_stage_if.sv
// kamus_decode_stage_if: fetch->decode->execute handshake bundle for the kamus ID stage
// Signals:
//   if_valid_i/if_ready_o/if_instr_i/if_pc_i  fetch side valid/ready transfer
//   flush_i                                   redirect kill
//   ex_valid_o/ex_ready_i                     execute side valid/ready
//   ex_decoded_o/ex_rd_o/ex_rs1_o/ex_rs2_o    decoded entry and register addresses
//   ex_illegal_o                              held entry is an illegal instruction
// Modports: master drives fetch/execute inputs, slave is the decode stage.
interface kamus_decode_stage_if #(parameter int DW = 85);
    logic          if_valid_i;
    logic          if_ready_o;
    logic [31:0]   if_instr_i;
    logic [31:0]   if_pc_i;
    logic          flush_i;
    logic          ex_valid_o;
    logic          ex_ready_i;
    logic [DW-1:0] ex_decoded_o;
    logic [4:0]    ex_rd_o;
    logic [4:0]    ex_rs1_o;
    logic [4:0]    ex_rs2_o;
    logic          ex_illegal_o;
    modport master (output if_valid_i, if_instr_i, if_pc_i, flush_i, ex_ready_i,
                    input if_ready_o, ex_valid_o, ex_decoded_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_illegal_o);
    modport slave  (input if_valid_i, if_instr_i, if_pc_i, flush_i, ex_ready_i,
                    output if_ready_o, ex_valid_o, ex_decoded_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_illegal_o);
endinterface

// File: rtl/kamus_decode_stage.sv
// kamus_decode_stage: RV32I ID stage decoding fetched words into a single-entry ID/EX register
// Ports: clk_i, rst_i (async, active-high), bus (kamus_decode_stage_if.slave: fetch handshake,
//   flush_i, execute handshake, decoded entry, rd/rs1/rs2, illegal flag).
// Parameter RESET_OP: operation loaded into the entry on reset/flush.
// Build option KAMUS_ZICSR_EN: enables CSRRW/CSRRS/CSRRC and their immediate forms.
package kamus_pkg;
    typedef enum logic [5:0] {
        INVALID, LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK, MRET, WFI, CSRRW, CSRRS, CSRRC
    } operation_e;
    typedef enum logic [1:0] {B = 2'b00, H = 2'b01, W = 2'b10} memory_width_e;
    typedef enum logic [4:0] {
        ZERO, RA, SP, GP, TP, T0, T1, T2, S0, S1, A0, A1, A2, A3, A4, A5,
        A6, A7, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, T3, T4, T5, T6
    } register_e;
    localparam logic [6:0] LUI_TYPE     = 7'b0110111;
    localparam logic [6:0] AUIPC_TYPE   = 7'b0010111;
    localparam logic [6:0] JAL_TYPE     = 7'b1101111;
    localparam logic [6:0] JALR_TYPE    = 7'b1100111;
    localparam logic [6:0] BRANCH_TYPE  = 7'b1100011;
    localparam logic [6:0] LOAD_TYPE    = 7'b0000011;
    localparam logic [6:0] STORE_TYPE   = 7'b0100011;
    localparam logic [6:0] OPIMM_TYPE   = 7'b0010011;
    localparam logic [6:0] OP_TYPE      = 7'b0110011;
    localparam logic [6:0] MISCMEM_TYPE = 7'b0001111;
    localparam logic [6:0] SYSTEM_TYPE  = 7'b1110011;
    localparam logic [2:0] F3_PRIV      = 3'b000;
    typedef struct packed {
        operation_e    operation;
        logic          immediate_used;
        logic [31:0]   immediate;
        logic [11:0]   funct12;
        logic [31:0]   pc;
        memory_width_e memory_width;
    } instr_decoded_t;
endpackage

module kamus_decode_stage
    import kamus_pkg::*;
#(
    parameter operation_e RESET_OP = INVALID
) (
    input logic clk_i,
    input logic rst_i,
    kamus_decode_stage_if.slave bus
);
    localparam instr_decoded_t RESET_DEC = '{operation: RESET_OP, immediate_used: 1'b0, immediate: 32'h0,
                                             funct12: 12'h0, pc: 32'h0, memory_width: W};
    logic           valid_q, valid_d, illegal_q, illegal_d, xfer;
    instr_decoded_t dec_q, dec_d, dec;
    register_e      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]    instr, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0]     f3;
    logic [6:0]     f7;
    logic [11:0]    f12;

    // Register-register and register-immediate ALU ops share one funct3 map.
    function automatic operation_e alu_op(input logic [2:0] f);
        case (f)
            3'b000:  return ADD;
            3'b001:  return SLL;
            3'b010:  return SLT;
            3'b011:  return SLTU;
            3'b100:  return XOR;
            3'b101:  return SRL;
            3'b110:  return OR;
            default: return AND;
        endcase
    endfunction

    assign instr = bus.if_instr_i;
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign f12   = instr[31:20];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec = '{operation: INVALID, immediate_used: 1'b0, immediate: 32'h0, funct12: f12,
                pc: bus.if_pc_i, memory_width: W};
        case (instr[6:0])
            LUI_TYPE:     begin dec.operation = LUI;   dec.immediate_used = 1'b1; dec.immediate = imm_u; end
            AUIPC_TYPE:   begin dec.operation = AUIPC; dec.immediate_used = 1'b1; dec.immediate = imm_u; end
            JAL_TYPE:     begin dec.operation = JAL;   dec.immediate_used = 1'b1; dec.immediate = imm_j; end
            JALR_TYPE: begin
                dec.operation      = (f3 == 3'b000) ? JALR : INVALID;
                dec.immediate_used = 1'b1;
                dec.immediate      = imm_i;
            end
            BRANCH_TYPE: begin
                // Branches carry their offset for target computation but are not immediate-ALU ops.
                dec.immediate = imm_b;
                case (f3)
                    3'b000:  dec.operation = BEQ;
                    3'b001:  dec.operation = BNE;
                    3'b100:  dec.operation = BLT;
                    3'b101:  dec.operation = BGE;
                    3'b110:  dec.operation = BLTU;
                    3'b111:  dec.operation = BGEU;
                    default: dec.operation = INVALID;
                endcase
            end
            LOAD_TYPE: begin
                dec.immediate_used = 1'b1;
                dec.immediate      = imm_i;
                dec.memory_width   = memory_width_e'(f3[1:0]);
                case (f3)
                    3'b000:  dec.operation = LB;
                    3'b001:  dec.operation = LH;
                    3'b010:  dec.operation = LW;
                    3'b100:  dec.operation = LBU;
                    3'b101:  dec.operation = LHU;
                    default: dec.operation = INVALID;
                endcase
            end
            STORE_TYPE: begin
                dec.immediate_used = 1'b1;
                dec.immediate      = imm_s;
                dec.memory_width   = memory_width_e'(f3[1:0]);
                dec.operation      = (f3 == 3'b000) ? SB : (f3 == 3'b001) ? SH : (f3 == 3'b010) ? SW : INVALID;
            end
            OPIMM_TYPE: begin
                // Only shifts constrain funct7; a nonzero instr[25] fails the f7 match.
                dec.immediate_used = 1'b1;
                dec.immediate      = imm_i;
                dec.operation      = (f3[1:0] != 2'b01) ? alu_op(f3) : (f7 == 7'b0) ? alu_op(f3) :
                                     (f3[2] && f7 == 7'b0100000) ? SRA : INVALID;
            end
            OP_TYPE:
                dec.operation = (f7 == 7'b0) ? alu_op(f3) :
                                (f7 == 7'b0100000 && f3 == 3'b000) ? SUB :
                                (f7 == 7'b0100000 && f3 == 3'b101) ? SRA : INVALID;
            MISCMEM_TYPE: dec.operation = (f3 == 3'b000) ? FENCE : INVALID;
            SYSTEM_TYPE: begin
                if (f3 == F3_PRIV) begin
                    case (f12)
                        12'h000: dec.operation = ECALL;
                        12'h001: dec.operation = EBREAK;
                        12'h302: dec.operation = MRET;
                        12'h105: dec.operation = WFI;
                        default: dec.operation = INVALID;
                    endcase
                end else begin
`ifdef KAMUS_ZICSR_EN
                    // funct3[2] selects the uimm form; the rs1 field becomes a zero-extended immediate.
                    dec.operation      = (f3[1:0] == 2'b01) ? CSRRW : (f3[1:0] == 2'b10) ? CSRRS :
                                         (f3[1:0] == 2'b11) ? CSRRC : INVALID;
                    dec.immediate_used = f3[2];
                    dec.immediate      = {27'h0, instr[19:15]};
`else
                    dec.operation = INVALID;
`endif
                end
            end
            default: dec.operation = INVALID;
        endcase
    end

    assign bus.if_ready_o = !valid_q | bus.ex_ready_i;
    assign xfer           = bus.if_valid_i & bus.if_ready_o;

    // Flush wins over a transfer and over a held entry; it reloads the reset image.
    always_comb begin
        valid_d   = bus.flush_i ? 1'b0 : xfer ? 1'b1 : valid_q & !bus.ex_ready_i;
        illegal_d = bus.flush_i ? 1'b0 : xfer ? (dec.operation == INVALID) : illegal_q;
        dec_d     = bus.flush_i ? RESET_DEC : xfer ? dec : dec_q;
        rd_d      = bus.flush_i ? ZERO : xfer ? register_e'(instr[11:7]) : rd_q;
        rs1_d     = bus.flush_i ? ZERO : xfer ? register_e'(instr[19:15]) : rs1_q;
        rs2_d     = bus.flush_i ? ZERO : xfer ? register_e'(instr[24:20]) : rs2_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            dec_q     <= RESET_DEC;
            rd_q      <= ZERO;
            rs1_q     <= ZERO;
            rs2_q     <= ZERO;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            dec_q     <= dec_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
        end
    end

    assign bus.ex_valid_o   = valid_q;
    assign bus.ex_illegal_o = illegal_q;
    assign bus.ex_decoded_o = dec_q;
    assign bus.ex_rd_o      = rd_q;
    assign bus.ex_rs1_o     = rs1_q;
    assign bus.ex_rs2_o     = rs2_q;
endmodule
